// File: rtl/pw_pkg.sv
// Package for the power-waster enable controller.
// Holds the controller state encoding and the default counter width.
package pw_pkg;

  localparam int unsigned CntWDefault = 16;

  typedef enum logic [1:0] {
    StIdle,
    StOn,
    StOff
  } pw_state_e;

endpackage

// File: rtl/pw_enable_ctrl.sv
// Burst enable generator for a ring-oscillator power-waster array.
// Runs a configurable number of bursts, each burst being on_cycles of enable high followed by
// off_cycles of enable low. A single phase counter times both the ON and OFF phases.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   cfg_valid / cfg_ready    config handshake, accepted only while idle
//   cfg_on_cycles            enable-high cycles per burst (0 makes start a no-op)
//   cfg_off_cycles           enable-low cycles per burst (0 = no low phase)
//   cfg_bursts               bursts per run (0 = run until stop)
//   start, stop              single-cycle run / abort requests (stop wins)
//   pw_enable                registered enable, high exactly while in ON
//   busy                     high whenever not idle
//   done                     one-cycle pulse on the cycle the run returns to idle normally
//   burst_cnt                bursts completed in the current or last run
module pw_enable_ctrl
  import pw_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_on_cycles,
  input  logic [CNT_W-1:0] cfg_off_cycles,
  input  logic [CNT_W-1:0] cfg_bursts,
  input  logic             start,
  input  logic             stop,
  output logic             pw_enable,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] burst_cnt
);

  localparam logic [CNT_W-1:0] One = CNT_W'(1);

  pw_state_e        state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0] on_q, on_d;
  logic [CNT_W-1:0] off_q, off_d;
  logic [CNT_W-1:0] bursts_q, bursts_d;
  logic             done_d;
  logic             burst_end;
  logic             pw_enable_q, busy_q, done_q, cfg_ready_q;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    burst_cnt_d = burst_cnt_q;
    on_d        = on_q;
    off_d       = off_q;
    bursts_d    = bursts_q;
    done_d      = 1'b0;
    burst_end   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Start looks at the shadow values held before any same-cycle cfg write.
        if (start && !stop && (on_q != '0)) begin
          state_d     = StOn;
          phase_d     = on_q - One;
          burst_cnt_d = '0;
        end
        if (cfg_valid && cfg_ready_q) begin
          on_d     = cfg_on_cycles;
          off_d    = cfg_off_cycles;
          bursts_d = cfg_bursts;
        end
      end
      StOn: begin
        if (phase_q == '0) begin
          if (off_q != '0) begin
            state_d = StOff;
            phase_d = off_q - One;
          end else begin
            burst_end = 1'b1;
          end
        end else begin
          phase_d = phase_q - One;
        end
      end
      StOff: begin
        if (phase_q == '0) begin
          burst_end = 1'b1;
        end else begin
          phase_d = phase_q - One;
        end
      end
      default: state_d = StIdle;
    endcase

    if (burst_end) begin
      burst_cnt_d = burst_cnt_q + One;
      if ((bursts_q != '0) && (burst_cnt_d == bursts_q)) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end else begin
        // Going straight back to ON keeps enable gap-free when there is no OFF phase.
        state_d = StOn;
        phase_d = on_q - One;
      end
    end

    // Abort: drop to idle, keep the completed-burst count, no done.
    if (stop && (state_q != StIdle)) begin
      state_d     = StIdle;
      phase_d     = phase_q;
      burst_cnt_d = burst_cnt_q;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      burst_cnt_q <= '0;
      on_q        <= '0;
      off_q       <= '0;
      bursts_q    <= '0;
      pw_enable_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      burst_cnt_q <= burst_cnt_d;
      on_q        <= on_d;
      off_q       <= off_d;
      bursts_q    <= bursts_d;
      pw_enable_q <= (state_d == StOn);
      busy_q      <= (state_d != StIdle);
      done_q      <= done_d;
      cfg_ready_q <= (state_d == StIdle);
    end
  end

  assign pw_enable = pw_enable_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_ready = cfg_ready_q;
  assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_pw_enable_ctrl.sv
// Directed bench for pw_enable_ctrl. Each step drives inputs for one cycle and pushes the
// outputs expected after the next rising edge; the step then pops and compares them.
module tb_pw_enable_ctrl;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic         pw;
    logic         busy;
    logic         done;
    logic [W-1:0] cnt;
    logic         ready;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_on_cycles;
  logic [W-1:0] cfg_off_cycles;
  logic [W-1:0] cfg_bursts;
  logic         start;
  logic         stop;
  logic         pw_enable;
  logic         busy;
  logic         done;
  logic [W-1:0] burst_cnt;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  pw_enable_ctrl #(.CNT_W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_on_cycles (cfg_on_cycles),
    .cfg_off_cycles(cfg_off_cycles),
    .cfg_bursts    (cfg_bursts),
    .start         (start),
    .stop          (stop),
    .pw_enable     (pw_enable),
    .busy          (busy),
    .done          (done),
    .burst_cnt     (burst_cnt)
  );

  always #5 clk = ~clk;

  // cfg_ready is expected high exactly when not busy.
  function automatic exp_t mk(input logic pw, input logic b, input logic d, input int cnt);
    exp_t e;
    e.pw    = pw;
    e.busy  = b;
    e.done  = d;
    e.cnt   = W'(cnt);
    e.ready = ~b;
    return e;
  endfunction

  task automatic cyc(input logic st, input logic sp, input logic cv, input exp_t e,
                     input string tag);
    exp_t exp_v;
    exp_t obs;
    start     = st;
    stop      = sp;
    cfg_valid = cv;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    start     = 1'b0;
    stop      = 1'b0;
    cfg_valid = 1'b0;
    exp_v = sb_q.pop_front();
    obs   = '{pw: pw_enable, busy: busy, done: done, cnt: burst_cnt, ready: cfg_ready};
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed pw=%b busy=%b done=%b cnt=%0d rdy=%b, expected pw=%b busy=%b done=%b cnt=%0d rdy=%b",
             tag, obs.pw, obs.busy, obs.done, obs.cnt, obs.ready,
             exp_v.pw, exp_v.busy, exp_v.done, exp_v.cnt, exp_v.ready);
    end
  endtask

  task automatic set_cfg(input int on, input int off, input int nb, input int cur_cnt);
    cfg_on_cycles  = W'(on);
    cfg_off_cycles = W'(off);
    cfg_bursts     = W'(nb);
    cyc(1'b0, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, cur_cnt), "cfg_write");
  endtask

  // Step k checks cycle k after the start edge. With poke set, a cfg write is attempted
  // while ON and a second start is issued mid-run; neither may disturb the pattern.
  task automatic run_pattern(input int on, input int off, input int nb, input int ncyc,
                             input bit poke, input string tag);
    int   len;
    logic st;
    logic cv;
    len = on + off;
    for (int k = 1; k <= ncyc; k++) begin
      st = (k == 1) || (poke && k == 7);
      cv = 1'b0;
      if (poke && k == 2) begin
        cfg_on_cycles  = W'(1);
        cfg_off_cycles = W'(0);
        cfg_bursts     = W'(1);
        cv = 1'b1;
      end
      cyc(st, 1'b0, cv, mk(((k - 1) % len) < on, 1'b1, 1'b0, (k - 1) / len), tag);
    end
    if (nb != 0 && ncyc == nb * len) begin
      cyc(1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b1, nb), "done_pulse");
      cyc(1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, nb), "done_clear");
    end
  endtask

  initial begin
    rst            = 1'b1;
    cfg_valid      = 1'b0;
    cfg_on_cycles  = '0;
    cfg_off_cycles = '0;
    cfg_bursts     = '0;
    start          = 1'b0;
    stop           = 1'b0;

    cyc(1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 0), "reset");
    cyc(1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 0), "reset_hold");
    rst = 1'b0;

    // Shadow on_cycles is 0 after reset: start ignored.
    cyc(1'b1, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 0), "start_on_zero");

    // Start together with a cfg write uses the old (zero) shadow, so still ignored.
    cfg_on_cycles  = W'(3);
    cfg_off_cycles = W'(2);
    cfg_bursts     = W'(2);
    cyc(1'b1, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 0), "start_with_cfg");

    // on=3 off=2 bursts=2: 1,1,1,0,0,1,1,1,0,0 then done with burst_cnt=2.
    run_pattern(3, 2, 2, 10, 1'b1, "run_3_2_2");

    cyc(1'b1, 1'b1, 1'b0, mk(1'b0, 1'b0, 1'b0, 2), "start_stop_idle");

    // Shadow must still be 3/2/2 despite the cfg attempt while ON.
    run_pattern(3, 2, 2, 10, 1'b0, "shadow_kept");

    // on=4 off=0 run forever; stop in cycle 10 -> low in cycle 11, burst_cnt=2.
    set_cfg(4, 0, 0, 2);
    run_pattern(4, 0, 0, 10, 1'b0, "continuous");
    cyc(1'b0, 1'b1, 1'b0, mk(1'b0, 1'b0, 1'b0, 2), "stop_running");
    cyc(1'b0, 1'b1, 1'b0, mk(1'b0, 1'b0, 1'b0, 2), "stop_idle");

    // Minimal run: a single one-cycle burst.
    set_cfg(1, 0, 1, 2);
    run_pattern(1, 0, 1, 1, 1'b0, "single_cycle");

    // 5-burst run reset during the OFF phase of burst 2, with start/stop/cfg in the same cycle.
    set_cfg(2, 3, 5, 1);
    run_pattern(2, 3, 5, 8, 1'b0, "five_burst_pre_rst");
    rst            = 1'b1;
    cfg_on_cycles  = W'(7);
    cfg_off_cycles = W'(7);
    cfg_bursts     = W'(7);
    cyc(1'b1, 1'b1, 1'b1, mk(1'b0, 1'b0, 1'b0, 0), "rst_priority");
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 0), "shadow_cleared");

    set_cfg(2, 3, 5, 0);
    run_pattern(2, 3, 5, 25, 1'b0, "five_burst_rerun");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
